// File: rtl/debouncer_teclado.sv
// Keypad debouncer for ten active-high key lines.
// The raw lines are double-flopped into the clock domain. A single one-hot
// key is accepted only after it has been stable for DEBOUNCE_CYCLES
// synchronized samples. Acceptance is marked by a one-cycle active-low
// strobe. The accepted key is released only after the lines have been all
// zero for the same number of samples.
module debouncer_teclado #(
  parameter int unsigned DEBOUNCE_CYCLES = 4  // legal range 2..255
) (
  input  logic       clk,
  input  logic       rst,          // synchronous, active-high
  input  logic [9:0] teclas,       // raw asynchronous key lines
  output logic [9:0] entrada,      // one-hot accepted key, zero when none
  output logic       enablen,      // active-low strobe per accepted press
  output logic       pressionada   // key accepted, release not confirmed
);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,  // waiting for a single clean key
    FILTRANDO   = 2'd1,  // candidate key must stay stable
    PRESSIONADO = 2'd2,  // key accepted; other activity is ignored
    LIBERANDO   = 2'd3   // lines are zero; confirming the release
  } state_t;

  // The counter must be able to hold DEBOUNCE_CYCLES itself.
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer stages. The FSM reads only sync_q.
  logic [9:0] meta_q;
  logic [9:0] sync_q;

  // FSM state and datapath registers
  state_t           state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [9:0]       captured_q,    captured_d;
  logic [9:0]       entrada_q,     entrada_d;
  logic             enablen_q,     enablen_d;
  logic             pressionada_q, pressionada_d;

  // Exactly one key is down: the value is nonzero and has no second set bit.
  logic sync_one_hot;
  assign sync_one_hot = (sync_q != 10'd0) && ((sync_q & (sync_q - 10'd1)) == 10'd0);

  // Two-flop synchronizer for the asynchronous key lines
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments, so
    // meta_q -> sync_q takes one full clock and does not collapse into one flop.
    if (rst) begin
      meta_q <= 10'd0;
      sync_q <= 10'd0;
    end else begin
      meta_q <= teclas;
      sync_q <= meta_q;
    end
  end

  // State and output registers. Reset wins over every pending transition,
  // including a strobe that the FSM has just requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= OCIOSO;
      cnt_q         <= '0;
      captured_q    <= 10'd0;
      entrada_q     <= 10'd0;
      enablen_q     <= 1'b1;
      pressionada_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      entrada_q     <= entrada_d;
      enablen_q     <= enablen_d;
      pressionada_q <= pressionada_d;
    end
  end

  // Next-state logic: filter presses and releases, and request the strobe
  always_comb begin
    // NOTE: every signal gets a default before the case. Otherwise a path
    // that leaves a signal unassigned would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    captured_d    = captured_q;
    entrada_d     = entrada_q;
    enablen_d     = 1'b1;
    pressionada_d = pressionada_q;

    unique case (state_q)
      OCIOSO: begin
        // Zero or multi-key patterns are never candidates.
        if (sync_one_hot) begin
          captured_d = sync_q;
          cnt_d      = CNT_ONE;
          state_d    = FILTRANDO;
        end
      end

      FILTRANDO: begin
        if (sync_q != captured_q) begin
          // Any change during filtering is a bounce. Drop it silently.
          cnt_d   = '0;
          state_d = OCIOSO;
        end else if (cnt_q == CNT_LAST) begin
          entrada_d     = captured_q;
          enablen_d     = 1'b0;
          pressionada_d = 1'b1;
          cnt_d         = '0;
          state_d       = PRESSIONADO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSIONADO: begin
        // Extra or different keys are ignored. Only all-zero starts a release.
        if (sync_q == 10'd0) begin
          cnt_d   = CNT_ONE;
          state_d = LIBERANDO;
        end
      end

      LIBERANDO: begin
        if (sync_q != 10'd0) begin
          // A release bounce: go back to holding without a new strobe.
          cnt_d   = '0;
          state_d = PRESSIONADO;
        end else if (cnt_q == CNT_LAST) begin
          entrada_d     = 10'd0;
          pressionada_d = 1'b0;
          cnt_d         = '0;
          state_d       = OCIOSO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = OCIOSO;
      end
    endcase
  end

  assign entrada     = entrada_q;
  assign enablen     = enablen_q;
  assign pressionada = pressionada_q;

endmodule

// File: tb/tb_debouncer_teclado.sv
// Directed testbench for debouncer_teclado with DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, so each sample shows the registers updated by that edge.
module tb_debouncer_teclado;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [9:0] teclas;
  logic [9:0] entrada;
  logic       enablen;
  logic       pressionada;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [9:0] K0  = 10'b0000000001;
  localparam logic [9:0] K3  = 10'b0000001000;
  localparam logic [9:0] K5  = 10'b0000100000;
  localparam logic [9:0] K9  = 10'b1000000000;
  localparam logic [9:0] K37 = 10'b0010001000;
  localparam logic [9:0] K02 = 10'b0000000101;

  debouncer_teclado #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .teclas      (teclas),
    .entrada     (entrada),
    .enablen     (enablen),
    .pressionada (pressionada)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    teclas = 10'd0;
    tick();
    tick();
    n_checks++;
    if (entrada !== 10'd0 || enablen !== 1'b1 || pressionada !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: entrada=%b enablen=%b pressionada=%b, required 0000000000/1/0",
               entrada, enablen, pressionada);
    end
    rst = 1'b0;
    tick();
  endtask

  // The key is applied before E0 and held. The strobe appears at E5 only.
  task automatic test_press(input logic [9:0] key, input string name);
    teclas = key;
    for (int e = 0; e < 8; e++) begin
      logic       exp_en;
      logic [9:0] exp_ent;
      logic       exp_pr;
      tick();
      exp_en  = (e == N + 1) ? 1'b0 : 1'b1;
      exp_ent = (e >= N + 1) ? key : 10'd0;
      exp_pr  = (e >= N + 1);
      n_checks++;
      if (enablen !== exp_en || entrada !== exp_ent || pressionada !== exp_pr) begin
        n_fail++;
        $display("FAIL press_%s E%0d: en=%b ent=%b pr=%b, required en=%b ent=%b pr=%b",
                 name, e, enablen, entrada, pressionada, exp_en, exp_ent, exp_pr);
      end
    end
  endtask

  // A second key is added while key 3 is held. It must not change anything.
  task automatic test_extra_key();
    teclas = K37;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_checks++;
      if (enablen !== 1'b1 || entrada !== K3 || pressionada !== 1'b1) begin
        n_fail++;
        $display("FAIL extra_key c%0d: en=%b ent=%b pr=%b, required en=1 ent=%b pr=1",
                 e, enablen, entrada, pressionada, K3);
      end
    end
    teclas = K3;
    tick();
    tick();
    tick();
  endtask

  // Release, bounce back for one cycle inside LIBERANDO, then release cleanly.
  task automatic test_release_bounce();
    teclas = 10'd0;
    tick();          // R0
    tick();          // R1: sync is now zero
    teclas = K3;
    tick();          // R2: FSM enters LIBERANDO
    teclas = 10'd0;  // final release, before R0'
    for (int e = 0; e < 8; e++) begin
      logic [9:0] exp_ent;
      logic       exp_pr;
      tick();
      exp_ent = (e >= N + 1) ? 10'd0 : K3;
      exp_pr  = (e < N + 1);
      n_checks++;
      if (enablen !== 1'b1 || entrada !== exp_ent || pressionada !== exp_pr) begin
        n_fail++;
        $display("FAIL release_bounce R%0d: en=%b ent=%b pr=%b, required en=1 ent=%b pr=%b",
                 e, enablen, entrada, pressionada, exp_ent, exp_pr);
      end
    end
  endtask

  // A clean release with no bounce clears the outputs at R5.
  task automatic test_release(input logic [9:0] key, input string name);
    teclas = 10'd0;
    for (int e = 0; e < 8; e++) begin
      logic [9:0] exp_ent;
      tick();
      exp_ent = (e >= N + 1) ? 10'd0 : key;
      n_checks++;
      if (enablen !== 1'b1 || entrada !== exp_ent || pressionada !== (e < N + 1)) begin
        n_fail++;
        $display("FAIL release_%s R%0d: en=%b ent=%b pr=%b, required en=1 ent=%b",
                 name, e, enablen, entrada, pressionada, exp_ent);
      end
    end
  endtask

  // A key pressed for only two cycles must never be accepted.
  task automatic test_glitch();
    teclas = K5;
    tick();
    tick();
    teclas = 10'd0;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_checks++;
      if (enablen !== 1'b1 || entrada !== 10'd0 || pressionada !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch c%0d: en=%b ent=%b pr=%b, required en=1 ent=0 pr=0",
                 e, enablen, entrada, pressionada);
      end
    end
  endtask

  // Two keys held together are never a candidate.
  task automatic test_two_keys();
    teclas = K02;
    for (int e = 0; e < 20; e++) begin
      tick();
      n_checks++;
      if (enablen !== 1'b1 || entrada !== 10'd0 || pressionada !== 1'b0) begin
        n_fail++;
        $display("FAIL two_keys c%0d: en=%b ent=%b pr=%b, required en=1 ent=0 pr=0",
                 e, enablen, entrada, pressionada);
      end
    end
    teclas = 10'd0;
    tick();
    tick();
    tick();
  endtask

  // Reset while FILTRANDO has cnt=2. The key is released with the reset.
  task automatic test_reset_mid_filter();
    teclas = K3;
    tick();  // E0
    tick();  // E1
    tick();  // E2: cnt=1
    tick();  // E3: cnt=2
    rst    = 1'b1;
    teclas = 10'd0;
    tick();  // E4: reset
    n_checks++;
    if (enablen !== 1'b1 || entrada !== 10'd0 || pressionada !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_filter: en=%b ent=%b pr=%b, required en=1 ent=0 pr=0",
               enablen, entrada, pressionada);
    end
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_checks++;
      if (enablen !== 1'b1 || entrada !== 10'd0 || pressionada !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_filter_after c%0d: en=%b ent=%b pr=%b, required en=1 ent=0 pr=0",
                 e, enablen, entrada, pressionada);
      end
    end
  endtask

  // Reset exactly at the strobe edge suppresses the strobe. The key is still
  // held, so after reset it is a new press with E0 = first edge with rst low.
  task automatic test_reset_at_strobe();
    teclas = K9;
    for (int e = 0; e < N; e++) tick();  // E0..E3; E4 would be next
    tick();                              // E4: cnt=3
    rst = 1'b1;
    tick();                              // E5: strobe would be here
    n_checks++;
    if (enablen !== 1'b1 || entrada !== 10'd0 || pressionada !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_at_strobe: en=%b ent=%b pr=%b, required en=1 ent=0 pr=0",
               enablen, entrada, pressionada);
    end
    tick();
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      logic exp_en;
      tick();
      exp_en = (e == N + 1) ? 1'b0 : 1'b1;
      n_checks++;
      if (enablen !== exp_en || entrada !== ((e >= N + 1) ? K9 : 10'd0)) begin
        n_fail++;
        $display("FAIL held_through_reset E%0d: en=%b ent=%b, required en=%b",
                 e, enablen, entrada, exp_en);
      end
    end
  endtask

  // Reset during LIBERANDO clears the accepted key at once.
  task automatic test_reset_mid_release();
    teclas = 10'd0;
    tick();
    tick();
    tick();  // LIBERANDO, cnt=1
    tick();  // cnt=2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (enablen !== 1'b1 || entrada !== 10'd0 || pressionada !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release: en=%b ent=%b pr=%b, required en=1 ent=0 pr=0",
               enablen, entrada, pressionada);
    end
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    teclas = 10'd0;
    test_reset();
    test_press(K3, "k3");
    test_extra_key();
    test_release_bounce();
    test_glitch();
    test_two_keys();
    test_press(K0, "k0");
    test_release(K0, "k0");
    test_reset_mid_filter();
    test_reset_at_strobe();
    test_reset_mid_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debouncer_teclado.md
DEBOUNCER_TECLADO -- requirements
Module: debouncer_teclado

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: the number N of consecutive stable synchronized samples needed to accept a press or a release; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port teclas, input, 10 bits: raw asynchronous key lines, active-high; teclas[k] is key k.
REQ-005 SHALL have port entrada, output, 10 bits: registered one-hot code of the accepted key; all zeros when no key is accepted.
REQ-006 SHALL have port enablen, output, 1 bit: registered, active-low, one-cycle strobe marking each newly accepted key.
REQ-007 SHALL have port pressionada, output, 1 bit: registered; high while a key is accepted and its release is not yet confirmed.

Function
REQ-008 SHALL pass teclas through a 2-flop synchronizer; the FSM SHALL see only the second stage (sync).
REQ-009 SHALL implement four states: OCIOSO, FILTRANDO, PRESSIONADO, LIBERANDO; counter width SHALL hold N.
REQ-010 OCIOSO: if sync is exactly one-hot, SHALL capture it, set cnt=1 and go to FILTRANDO; if sync is zero or has more than one bit set, SHALL stay in OCIOSO.
REQ-011 FILTRANDO: if sync differs from the captured value, SHALL clear cnt and return to OCIOSO with no strobe.
REQ-012 FILTRANDO: if sync matches and cnt==N-1, SHALL load entrada with the captured value, drive enablen=0 for the next cycle only, set pressionada=1 and go to PRESSIONADO; otherwise SHALL increment cnt.
REQ-013 Press latency: for a key applied before edge E0 and held, enablen SHALL be low only between E(N+1) and E(N+2); entrada SHALL be valid from E(N+1).
REQ-014 PRESSIONADO: SHALL hold entrada; a nonzero sync of any value (extra keys, a different key) SHALL be ignored; sync==0 SHALL set cnt=1 and go to LIBERANDO.
REQ-015 LIBERANDO: a nonzero sync SHALL clear cnt and return to PRESSIONADO with no new strobe and entrada unchanged.
REQ-016 LIBERANDO: sync==0 with cnt==N-1 SHALL clear entrada to 0, set pressionada=0 and go to OCIOSO; otherwise SHALL increment cnt.
REQ-017 Release latency: a release before edge R0, held, SHALL clear entrada and pressionada at edge R(N+1).
REQ-018 enablen SHALL be high in every cycle except the single strobe cycle in REQ-012; at most one strobe SHALL occur per accepted press.
REQ-019 entrada SHALL always be either all zeros or exactly one-hot.

Reset
REQ-020 With rst high at a rising edge, the block SHALL set: state=OCIOSO, cnt=0, both synchronizer stages=0, captured value=0, entrada=0, enablen=1, pressionada=0.
REQ-021 Reset SHALL take priority over every transition, including mid-FILTRANDO, mid-strobe and mid-LIBERANDO; a strobe pending at the reset edge SHALL be suppressed.
REQ-022 After reset deasserts, a key held throughout reset SHALL be treated as a new press and follow REQ-013 timing, with E0 = the first edge with rst low.

Verification (N=4)
REQ-023 Hold teclas=10'b0000001000 from E0 -> enablen=0 only in the cycle E5..E6; entrada=10'b0000001000 and pressionada=1 from E5.
REQ-024 teclas=10'b0000100000 for 2 cycles, then 0 -> enablen stays 1 and entrada stays 0 throughout.
REQ-025 teclas=10'b0000000101 held 20 cycles -> no strobe; entrada=0 and pressionada=0.
REQ-026 After key 3 is accepted, add key 7 (teclas=10'b0010001000) -> entrada stays 10'b0000001000 and no second strobe.
REQ-027 During LIBERANDO, key 3 bounces back for 1 cycle, then releases cleanly -> no strobe; entrada clears 5 edges after the final release.
REQ-028 rst pulsed while in FILTRANDO with cnt=2 -> all outputs return to reset values the next cycle and no strobe follows.
